noc_packet_source: RTL and testbench
====================================

NOC_PACKET_SOURCE -- requirements
Module: noc_packet_source

Interface
REQ-001 The block SHALL expose parameter DEST_W, default 2, destination field width.
REQ-002 The block SHALL expose parameter TYPE_W, default 2, packet type field width.
REQ-003 The block SHALL expose parameter PAYLOAD_W, default 8, payload field width.
REQ-004 The block SHALL expose parameter LEN_W, default 4, width of flits-per-packet and packet-count fields.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  launch a burst; sampled only in IDLE.
REQ-008 cfg_dest  input  DEST_W  first destination of the burst.
REQ-009 cfg_type  input  TYPE_W  packet type, constant for the burst.
REQ-010 cfg_len  input  LEN_W  flits per packet; 0 treated as 1.
REQ-011 cfg_count  input  LEN_W  packets per burst; 0 = empty burst.
REQ-012 cfg_mode  input  2  payload mode: 0 FIXED, 1 INCR, 2 LFSR, 3 reserved (acts as FIXED).
REQ-013 cfg_seed  input  PAYLOAD_W  FIXED value, INCR start value, or LFSR seed.
REQ-014 cfg_dest_rr  input  1  1 = destination increments per packet.
REQ-015 ready_out  input  1  router accepts the flit this cycle.
REQ-016 valid_in  output  1  flit on packet_out is valid.
REQ-017 packet_out  output  DEST_W+TYPE_W+PAYLOAD_W+1  flit {dest, type, payload, eop}, eop is LSB.
REQ-018 busy  output  1  high in SEND and DONE.
REQ-019 done  output  1  one-cycle pulse at burst end.

Function
REQ-020 The FSM SHALL have states IDLE, SEND and DONE.
REQ-021 In IDLE, start=1 SHALL register all cfg_* inputs and move to SEND next cycle, or to DONE if cfg_count=0; busy asserts that same next cycle.
REQ-022 valid_in SHALL be 1 in every SEND cycle, starting on the first SEND cycle; latency from start to first valid flit is exactly 1 cycle.
REQ-023 A flit SHALL transfer when valid_in && ready_out; packet_out and valid_in SHALL hold stable while ready_out=0.
REQ-024 eop SHALL be 1 only on flit index len-1 of each packet; with len=1 every flit has eop=1.
REQ-025 After a transfer with eop=1, the next packet's first flit SHALL be presented the next cycle with no bubble; after the last packet the FSM SHALL go to DONE.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE; start SHALL be ignored in SEND and DONE.
REQ-027 With cfg_dest_rr=1, dest SHALL increment by 1 per packet, mod 2^DEST_W; otherwise it stays at cfg_dest.
REQ-028 FIXED: every payload SHALL equal cfg_seed.
REQ-029 INCR: payload SHALL start at cfg_seed and increment by 1 per transferred flit, mod 2^PAYLOAD_W, continuing across packet boundaries.
REQ-030 LFSR: payload SHALL start at cfg_seed (0 replaced by 1) and advance one right-shift Galois step per transferred flit, using the taps constant from the package (0xB8 for PAYLOAD_W=8).
REQ-031 Payload, flit and packet counters SHALL advance only on transfer.
REQ-032 Flit counters SHALL use LEN_W bits; cfg_len and cfg_count up to 2^LEN_W-1 SHALL work without wrap.

Reset
REQ-033 Reset SHALL force IDLE, valid_in=0, packet_out=0, busy=0, done=0, and clear all counters.
REQ-034 Reset mid-burst SHALL abort the burst with no further flits; after release the block SHALL wait in IDLE for a new start.

Structure
REQ-035 Package noc_pkg SHALL hold the flit struct typedef, the payload-mode enum, the default field widths and the LFSR taps constant.
REQ-036 Payload generation (FIXED/INCR/LFSR, load and advance-on-transfer) SHALL be a sub-module named noc_payload_gen.

Verification
REQ-037 len=1, count=1, FIXED seed 0xAA, dest 0, type 0, ready_out=1 -> one flit 13'h0155, then done pulse 2 cycles after start.
REQ-038 len=3, count=2, INCR seed 0xFE, dest_rr=1, dest 3 -> payloads FE,FF,00 to dest 3 and 01,02,03 to dest 0; eop on the 3rd and 6th flits; no bubble between packets.
REQ-039 LFSR seed 0x00, len=4, count=1 -> payloads 01, B8, 5C, 2E.
REQ-040 ready_out toggled 1,0,0,1 during INCR burst -> flit held unchanged through the stalled cycles; no payload skipped or repeated.
REQ-041 count=0 -> no valid_in; busy and done high for one cycle, one cycle after start.
REQ-042 Reset asserted on the 2nd flit of a len=4 burst -> valid_in=0 immediately; no flits after release until a new start.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC packet source: field widths, flit layout, payload modes, LFSR taps.
// No logic of its own; widths here are the defaults the RTL parameters start from.
package noc_pkg;

  localparam int DEST_W_DEF    = 2;
  localparam int TYPE_W_DEF    = 2;
  localparam int PAYLOAD_W_DEF = 8;
  localparam int LEN_W_DEF     = 4;
  localparam int FLIT_W_DEF    = DEST_W_DEF + TYPE_W_DEF + PAYLOAD_W_DEF + 1;

  // Right-shift Galois taps (x^8+x^6+x^5+x^4+1), maximal length for 8 bits
  localparam logic [PAYLOAD_W_DEF-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_INCR  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_RSVD  = 2'd3
  } payload_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEST_W_DEF-1:0]    dest;
    logic [TYPE_W_DEF-1:0]    ptype;
    logic [PAYLOAD_W_DEF-1:0] payload;
    logic                     eop;
  } flit_t;

  // Taps for payload widths other than the default; unknown widths fall back to the 8-bit set.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      4:       lfsr_taps = 32'h0000_000C;
      8:       lfsr_taps = 32'(LFSR_TAPS);
      16:      lfsr_taps = 32'h0000_B400;
      32:      lfsr_taps = 32'hA300_0000;
      default: lfsr_taps = 32'(LFSR_TAPS);
    endcase
  endfunction

endpackage

// File: rtl/noc_packet_source_if.sv
// Flit stream from the packet source to the router: valid/ready handshake plus the flit bus.
// Transfer on valid_in && ready_out; the source holds the flit stable while ready_out is low.
interface noc_packet_source_if #(
  parameter int FLIT_W = noc_pkg::FLIT_W_DEF
);
  logic              valid_in;
  logic              ready_out;
  logic [FLIT_W-1:0] packet_out;

  modport master (output valid_in, output packet_out, input ready_out);
  modport slave  (input valid_in, input packet_out, output ready_out);
endinterface

// File: rtl/noc_payload_gen.sv
// Payload generator: FIXED / INCR / LFSR value, loaded at burst launch, advanced once per transferred flit.
// Registered output, zero latency to the flit bus; holds its value while advance_i is low (stall).
module noc_payload_gen
  import noc_pkg::*;
#(
  parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  payload_mode_e        mode_i,
  input  logic [PAYLOAD_W-1:0] seed_i,
  input  logic                 advance_i,
  output logic [PAYLOAD_W-1:0] payload_o
);

  localparam logic [PAYLOAD_W-1:0] TAPS = PAYLOAD_W'(lfsr_taps(PAYLOAD_W));

  payload_mode_e        mode_q, mode_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;

  always_comb begin
    mode_d    = mode_q;
    payload_d = payload_q;
    if (load_i) begin
      mode_d = mode_i;
      // An all-zero LFSR state would lock up, so a zero seed starts from 1
      payload_d = (mode_i == MODE_LFSR && seed_i == '0) ? PAYLOAD_W'(1) : seed_i;
    end else if (advance_i) begin
      unique case (mode_q)
        MODE_INCR: payload_d = payload_q + PAYLOAD_W'(1);
        MODE_LFSR: payload_d = (payload_q >> 1) ^ (payload_q[0] ? TAPS : '0);
        default:   payload_d = payload_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= MODE_FIXED;
      payload_q <= '0;
    end else begin
      mode_q    <= mode_d;
      payload_q <= payload_d;
    end
  end

  assign payload_o = payload_q;

endmodule

// File: rtl/noc_packet_source.sv
// Burst packet source: on start, emits cfg_count packets of cfg_len flits each, then pulses done.
// First flit valid 1 cycle after start; flit held stable while ready_out is low, counters advance only on transfer.
module noc_packet_source
  import noc_pkg::*;
#(
  parameter int DEST_W    = DEST_W_DEF,
  parameter int TYPE_W    = TYPE_W_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int LEN_W     = LEN_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DEST_W-1:0]    cfg_dest,
  input  logic [TYPE_W-1:0]    cfg_type,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic [LEN_W-1:0]     cfg_count,
  input  logic [1:0]           cfg_mode,
  input  logic [PAYLOAD_W-1:0] cfg_seed,
  input  logic                 cfg_dest_rr,
  output logic                 busy,
  output logic                 done,
  noc_packet_source_if.master  flit_if
);

  state_e              state_q, state_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic [TYPE_W-1:0]   type_q, type_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic                rr_q, rr_d;
  logic [LEN_W-1:0]    flit_q, flit_d;
  logic [LEN_W-1:0]    pkt_q, pkt_d;
  logic [PAYLOAD_W-1:0] payload;
  logic                valid;
  logic                launch;
  logic                xfer;
  logic                eop;
  logic                last_pkt;

  assign launch   = (state_q == ST_IDLE) && start;
  assign xfer     = valid && flit_if.ready_out;
  assign eop      = (flit_q == len_q - LEN_W'(1));
  assign last_pkt = (pkt_q == count_q - LEN_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = (cfg_count == '0) ? ST_DONE : ST_SEND;
      ST_SEND: if (xfer && eop && last_pkt) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      ST_SEND: begin
        valid = 1'b1;
        busy  = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    dest_d  = dest_q;
    type_d  = type_q;
    len_d   = len_q;
    count_d = count_q;
    rr_d    = rr_q;
    flit_d  = flit_q;
    pkt_d   = pkt_q;
    if (launch) begin
      dest_d  = cfg_dest;
      type_d  = cfg_type;
      len_d   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
      count_d = cfg_count;
      rr_d    = cfg_dest_rr;
      flit_d  = '0;
      pkt_d   = '0;
    end else if (xfer) begin
      if (eop) begin
        flit_d = '0;
        pkt_d  = pkt_q + LEN_W'(1);
        dest_d = dest_q + DEST_W'(rr_q);
      end else begin
        flit_d = flit_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dest_q  <= '0;
      type_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      rr_q    <= 1'b0;
      flit_q  <= '0;
      pkt_q   <= '0;
    end else begin
      dest_q  <= dest_d;
      type_q  <= type_d;
      len_q   <= len_d;
      count_q <= count_d;
      rr_q    <= rr_d;
      flit_q  <= flit_d;
      pkt_q   <= pkt_d;
    end
  end

  noc_payload_gen #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_payload_gen (
    .clk       (clk),
    .reset     (reset),
    .load_i    (launch),
    .mode_i    (payload_mode_e'(cfg_mode)),
    .seed_i    (cfg_seed),
    .advance_i (xfer),
    .payload_o (payload)
  );

  // The bus reads zero outside SEND so idle/reset state never shows stale fields
  assign flit_if.valid_in   = valid;
  assign flit_if.packet_out = valid ? {dest_q, type_q, payload, eop} : '0;

endmodule

// File: tb/tb_noc_packet_source.sv
// Randomized and directed bursts against a queue-based reference model; a monitor scores every transfer and stall.
module tb_noc_packet_source;
  import noc_pkg::*;

  localparam int FW = FLIT_W_DEF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] cfg_dest = '0, cfg_type = '0, cfg_mode = '0;
  logic [3:0] cfg_len = '0, cfg_count = '0;
  logic [7:0] cfg_seed = '0;
  logic       cfg_dest_rr = 1'b0;
  logic       busy, done;

  noc_packet_source_if #(.FLIT_W(FW)) nif();

  noc_packet_source dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cfg_dest    (cfg_dest),
    .cfg_type    (cfg_type),
    .cfg_len     (cfg_len),
    .cfg_count   (cfg_count),
    .cfg_mode    (cfg_mode),
    .cfg_seed    (cfg_seed),
    .cfg_dest_rr (cfg_dest_rr),
    .busy        (busy),
    .done        (done),
    .flit_if     (nif)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  flit_t exp_q[$];
  int    rdy_mode = 0;
  logic  rdy_pat[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: list every flit of the burst in order, straight from the burst rules
  task automatic model(input logic [1:0] d, input logic [1:0] t, input logic [3:0] l,
                       input logic [3:0] c, input logic [1:0] m, input logic [7:0] s, input logic rr);
    int    len;
    logic [7:0] p;
    flit_t f;
    len = (l == 0) ? 1 : int'(l);
    p = (m == 2'd2 && s == 8'h00) ? 8'h01 : s;
    for (int k = 0; k < int'(c); k++) begin
      for (int i = 0; i < len; i++) begin
        f.dest    = rr ? 2'(int'(d) + k) : d;
        f.ptype   = t;
        f.payload = p;
        f.eop     = (i == len - 1);
        exp_q.push_back(f);
        case (m)
          2'd1:    p = p + 8'd1;
          2'd2:    p = {1'b0, p[7:1]} ^ (p[0] ? 8'hB8 : 8'h00);
          default: p = p;
        endcase
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       nif.ready_out = 1'($urandom_range(0, 1));
      2:       nif.ready_out = (rdy_pat.size() != 0) ? rdy_pat.pop_front() : 1'b1;
      default: nif.ready_out = 1'b1;
    endcase
  end

  logic          stall_pend = 1'b0;
  logic [FW-1:0] held;
  flit_t         exp_f;

  always @(negedge clk) begin
    if (reset) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("stall_hold_valid", 32'(nif.valid_in), 32'd1);
        chk("stall_hold_flit", 32'(nif.packet_out), 32'(held));
      end
      if (nif.valid_in && nif.ready_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_flit", 32'(nif.packet_out), 32'hFFFF_FFFF);
        end else begin
          exp_f = exp_q.pop_front();
          chk("flit", 32'(nif.packet_out), 32'(exp_f));
        end
        stall_pend = 1'b0;
      end else if (nif.valid_in) begin
        stall_pend = 1'b1;
        held       = nif.packet_out;
      end else begin
        stall_pend = 1'b0;
      end
    end
  end

  task automatic run_burst(input logic [1:0] d, input logic [1:0] t, input logic [3:0] l,
                           input logic [3:0] c, input logic [1:0] m, input logic [7:0] s,
                           input logic rr, input bit timed);
    int n;
    int nfl;
    nfl = ((l == 0) ? 1 : int'(l)) * int'(c);
    model(d, t, l, c, m, s, rr);
    @(posedge clk);
    #1;
    cfg_dest = d; cfg_type = t; cfg_len = l; cfg_count = c;
    cfg_mode = m; cfg_seed = s; cfg_dest_rr = rr;
    start = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("valid_first_cycle", 32'(nif.valid_in), 32'(c != 0));
        // Scramble cfg and keep start high: both must be ignored now
        cfg_dest = 2'($urandom); cfg_type = 2'($urandom); cfg_len = 4'($urandom);
        cfg_count = 4'($urandom); cfg_mode = 2'($urandom); cfg_seed = 8'($urandom);
        cfg_dest_rr = 1'($urandom);
      end
      if (n == 2) start = 1'b0;
    end while (!done && n < 4000);
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_with_done", 32'(busy), 32'd1);
    if (timed) chk("done_latency", 32'(n), 32'((c == 0) ? 1 : nfl + 1));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int bad;
    nif.ready_out = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(nif.valid_in), 32'd0);
    chk("rst_packet", 32'(nif.packet_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    run_burst(2'd0, 2'd0, 4'd1, 4'd1, 2'd0, 8'hAA, 1'b0, 1'b1);
    run_burst(2'd3, 2'd0, 4'd3, 4'd2, 2'd1, 8'hFE, 1'b1, 1'b1);
    run_burst(2'd0, 2'd0, 4'd4, 4'd1, 2'd2, 8'h00, 1'b0, 1'b1);
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    rdy_mode = 2;
    run_burst(2'd1, 2'd2, 4'd4, 4'd1, 2'd1, 8'h10, 1'b0, 1'b0);
    rdy_mode = 0;
    run_burst(2'd2, 2'd1, 4'd3, 4'd0, 2'd1, 8'h05, 1'b0, 1'b1);
    run_burst(2'd1, 2'd3, 4'd0, 4'd3, 2'd3, 8'h66, 1'b1, 1'b1);
    run_burst(2'd1, 2'd3, 4'd15, 4'd15, 2'd1, 8'h30, 1'b1, 1'b1);

    // Reset while the second flit of a len=4 burst is on the bus
    model(2'd0, 2'd1, 4'd4, 4'd2, 2'd1, 8'h40, 1'b0);
    @(posedge clk);
    #1;
    cfg_dest = 2'd0; cfg_type = 2'd1; cfg_len = 4'd4; cfg_count = 4'd2;
    cfg_mode = 2'd1; cfg_seed = 8'h40; cfg_dest_rr = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 chk("pre_reset_valid", 32'(nif.valid_in), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(nif.valid_in), 32'd0);
    chk("midrst_packet", 32'(nif.packet_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (nif.valid_in || busy || done) bad++;
    end
    chk("quiet_after_reset", 32'(bad), 32'd0);

    rdy_mode = 1;
    repeat (25) begin
      run_burst(2'($urandom), 2'($urandom), 4'($urandom_range(0, 6)), 4'($urandom_range(0, 5)),
                2'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    end
    rdy_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
